// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority arbiter sharing one memory port between fetch and data requesters (optional address range check via MEM_ARB_RANGE_CHECK_EN)
module mem_arbiter #(
    parameter logic [31:0] INSTR_BASE  = 32'h0000_0000,
    parameter logic [31:0] INSTR_LIMIT = 32'h0000_FFFF,
    parameter logic [31:0] DATA_BASE   = 32'h0001_0000,
    parameter logic [31:0] DATA_LIMIT  = 32'h0001_FFFF,
    parameter logic [7:0]  TIMEOUT     = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    input  logic        data_ld,
    input  logic        data_st,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] instr_rdata,
    output logic [31:0] data_rdata,
    output logic        wait_instr,
    output logic        wait_data,
    output logic        instr_segv,
    output logic        data_segv
);
    typedef enum logic [1:0] {IDLE, INSTR, DATA, RESP} state_t;
`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif
    state_t      state;
    logic        owner_data;
    logic        owner_st;
    logic [7:0]  cnt;
    logic        data_any;
    logic        data_ok;
    logic        instr_ok;
    logic        in_resp;
    assign data_any   = data_ld | data_st;
    assign data_ok    = !RANGE_CHECK || (data_addr >= DATA_BASE && data_addr <= DATA_LIMIT);
    assign instr_ok   = !RANGE_CHECK || (instr_addr >= INSTR_BASE && instr_addr <= INSTR_LIMIT);
    assign in_resp    = state == RESP;
    assign wait_instr = instr_req && !(in_resp && !owner_data);
    assign wait_data  = data_any && !(in_resp && owner_data);
    // arbitration FSM with registered memory strobes, read results and fault pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            owner_data  <= 1'b0;
            owner_st    <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            instr_rdata <= 32'h0;
            data_rdata  <= 32'h0;
            instr_segv  <= 1'b0;
            data_segv   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (data_any) begin
                        owner_data <= 1'b1;
                        owner_st   <= data_st;
                        mem_addr   <= data_addr;
                        mem_wdata  <= data_wdata;
                        state      <= data_ok ? DATA : RESP;
                        mem_rd     <= data_ok && data_ld;
                        mem_wr     <= data_ok && data_st;
                        data_segv  <= !data_ok;
                    end else if (instr_req) begin
                        owner_data <= 1'b0;
                        owner_st   <= 1'b0;
                        mem_addr   <= instr_addr;
                        state      <= instr_ok ? INSTR : RESP;
                        mem_rd     <= instr_ok;
                        instr_segv <= !instr_ok;
                    end
                end
                INSTR, DATA: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ready) begin
                        state  <= RESP;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!owner_st && owner_data) data_rdata <= mem_rdata;
                        if (!owner_data) instr_rdata <= mem_rdata;
                    end else if (cnt + 8'd1 == TIMEOUT) begin
                        state      <= RESP;
                        mem_rd     <= 1'b0;
                        mem_wr     <= 1'b0;
                        data_segv  <= owner_data;
                        instr_segv <= !owner_data;
                    end
                end
                default: begin
                    state      <= IDLE;
                    instr_segv <= 1'b0;
                    data_segv  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction-level checks of mem_arbiter
module tb_mem_arbiter;
    localparam int TO = 8;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req, data_ld, data_st, mem_ready;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic        mem_rd, mem_wr, wait_instr, wait_data, instr_segv, data_segv;
    logic [31:0] mem_addr, mem_wdata, instr_rdata, data_rdata;
    logic [31:0] exp_i, exp_d;
    int          total = 0;
    int          bad = 0;

    mem_arbiter #(.TIMEOUT(8'd8)) dut (
        .clk(clk), .reset(reset), .instr_req(instr_req), .instr_addr(instr_addr),
        .data_ld(data_ld), .data_st(data_st), .data_addr(data_addr), .data_wdata(data_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .instr_rdata(instr_rdata),
        .data_rdata(data_rdata), .wait_instr(wait_instr), .wait_data(wait_data),
        .instr_segv(instr_segv), .data_segv(data_segv)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction from its IDLE cycle to the IDLE after RESP; lat is the
    // active cycle (1-based) that sees mem_ready, lat > TO means it never comes.
    task automatic txn(input bit d, input bit st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int lat);
        int k;
        bit tmo;
        if (d) begin
            data_ld = !st; data_st = st; data_addr = a; data_wdata = wd;
        end else begin
            instr_req = 1'b1; instr_addr = a;
        end
        mem_ready = 1'b0;
        #1;
        chk("grant_wait", d ? wait_data : wait_instr, 1);
        chk("grant_idle_strobe", mem_rd | mem_wr, 0);
        k = 0;
        do begin
            k++;
            step();
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            #1;
            chk("act_rd", mem_rd, d ? !st : 1);
            chk("act_wr", mem_wr, d && st);
            chk("act_addr", mem_addr, a);
            if (d && st) chk("act_wdata", mem_wdata, wd);
            chk("act_wait", d ? wait_data : wait_instr, 1);
            chk("act_segv", instr_segv | data_segv, 0);
        end while (k != lat && k != TO);
        tmo = lat > TO;
        step();
        mem_ready = 1'b0;
        #1;
        chk("resp_ack", d ? wait_data : wait_instr, 0);
        chk("resp_other_wait", d ? wait_instr : wait_data, d ? instr_req : (data_ld | data_st));
        chk("resp_isegv", instr_segv, !d && tmo);
        chk("resp_dsegv", data_segv, d && tmo);
        chk("resp_strobes", mem_rd | mem_wr, 0);
        if (!st && !tmo) begin
            if (d) exp_d = rd;
            else exp_i = rd;
        end
        if (d) begin
            data_ld = 1'b0; data_st = 1'b0;
        end else instr_req = 1'b0;
        step();
        chk("idle_irdata", instr_rdata, exp_i);
        chk("idle_drdata", data_rdata, exp_d);
        chk("idle_segv", instr_segv | data_segv, 0);
        chk("idle_rd", mem_rd, 0);
    endtask

    initial begin
        reset = 1'b1; instr_req = 1'b0; data_ld = 1'b0; data_st = 1'b0; mem_ready = 1'b0;
        instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; mem_rdata = 32'h0;
        exp_i = 32'h0; exp_d = 32'h0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_segv", instr_segv | data_segv, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_irdata", instr_rdata, 0);
        chk("rst_drdata", data_rdata, 0);
        chk("rst_wait", wait_instr | wait_data, 0);
        // minimum-latency fetch
        txn(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
        // data wins over a simultaneous fetch, fetch follows
        instr_req = 1'b1;
        instr_addr = 32'h20;
        txn(1, 0, 32'h1_0004, 32'h0, 32'h1234_5678, 1);
        txn(0, 0, 32'h20, 32'h0, 32'h8765_4321, 3);
        // delayed store
        txn(1, 1, 32'h1_0008, 32'h55AA, 32'hFFFF_FFFF, 6);
        // fetch timeout, then ready arriving exactly at the timeout cycle
        txn(0, 0, 32'h30, 32'h0, 32'h0, 20);
        txn(1, 0, 32'h1_0020, 32'h0, 32'hABCD_0123, TO);
        // out-of-range load is a normal load without the range check
        txn(1, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 2);
        // reset in the middle of a load, held request re-granted afterwards
        data_ld = 1'b1;
        data_addr = 32'h1_0010;
        #1;
        step();
        step();
        chk("pre_rst_rd", mem_rd, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_rd", mem_rd, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_irdata", instr_rdata, 0);
        chk("mid_rst_drdata", data_rdata, 0);
        reset = 1'b0;
        exp_i = 32'h0;
        exp_d = 32'h0;
        step();
        chk("regrant_rd", mem_rd, 1);
        chk("regrant_addr", mem_addr, 32'h1_0010);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ready = 1'b0;
        chk("regrant_ack", wait_data, 0);
        data_ld = 1'b0;
        exp_d = 32'h0BAD_F00D;
        step();
        chk("regrant_drdata", data_rdata, exp_d);
        // randomized transactions
        for (int n = 0; n < 30; n++) begin
            bit d, st;
            d = 1'($urandom);
            st = d && 1'($urandom);
            txn(d, st, $urandom, $urandom, $urandom, int'($urandom_range(1, TO + 3)));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
